lfsr_checker: RTL
=================

// Module: lfsr_checker
// PURPOSE
//  Receive-side checker for the team's 8-bit LFSR stream (x^8+x^6+x^5+x^4+1). Takes one serial bit per
//  valid cycle, self-synchronises a local reference, then compares every received bit against it.
//  Reports lock, per-bit errors and saturating error/bit counts, and drops lock on a burst of errors.
//  Sits at the consumer end of any link carrying the generator's serial feedback bit.
// PARAMETERS
//  SYNC_LEN    16  consecutive correct predictions (after 8-bit fill) needed to lock
//  WIN_LEN     64  valid bits per error-monitoring window while locked
//  ERR_THRESH   4  errors within one window that force loss of lock
//  CNT_W       16  width of err_count / bit_count
// PORTS
//  clk        in   1      clock
//  reset      in   1      asynchronous, active-low reset
//  bit_in     in   1      received serial bit, sampled only when bit_valid=1
//  bit_valid  in   1      qualifies bit_in for this cycle
//  clear      in   1      synchronous clear of err_count and bit_count
//  locked     out  1      1 while FSM is in LOCKED
//  err_pulse  out  1      1-cycle pulse, one cycle after a mismatching bit is sampled in LOCKED
//  err_count  out  CNT_W  total mismatches while locked, saturating at all-ones
//  bit_count  out  CNT_W  valid bits sampled while locked, saturating at all-ones
//  zero_stuck out  1      all-zero stream detected in SEARCH (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, reset=0): FSM=SEARCH, shreg=0, fill/sync/window counters=0, all outputs 0.
//  - shreg[7:0], newest bit in [0]; pred = shreg[7]^shreg[5]^shreg[4]^shreg[3].
//  - bit_valid=0: no state, shreg, counter change; err_pulse=0.
//  - SEARCH: shreg <= {shreg[6:0],bit_in}. First 8 valid bits after entry only fill (fill_cnt 0..8).
//    After fill: bit_in==pred -> sync_cnt+1; mismatch -> sync_cnt=0. On SYNC_LEN-th consecutive match
//    -> LOCKED; locked=1 the cycle after that bit is sampled. No err_pulse/err_count in SEARCH.
//  - LOCKED: shreg <= {shreg[6:0],pred} (free-running; received errors never corrupt the reference).
//    err = bit_in!=pred -> err_pulse next cycle, err_count+1 (saturating); bit_count+1 every valid bit.
//    win_cnt 0..WIN_LEN-1 counts valid bits, win_err counts errors; both zero after bit WIN_LEN-1 is sampled.
//    If win_err+err reaches ERR_THRESH -> SEARCH; locked=0 the cycle after that bit; fill/sync/window
//    counters cleared; err_count and bit_count retained; the errored bit's err_pulse still fires.
//  - clear: zeroes err_count/bit_count next cycle; clear wins over a simultaneous increment; FSM unaffected.
//  - Counters saturate, never wrap. Reset mid-operation returns everything to reset values immediately.
// CONFIGURATION
//  Macro LFSR_CHK_ZERO_DET_EN:
//  - defined: in SEARCH after fill, a valid bit leaving shreg all-zero sets zero_stuck=1 (next cycle) and
//    holds sync_cnt=0, so an all-zero line (LFSR lock-up fixed point) can never lock; any valid 1 clears it.
//  - undefined: zero_stuck tied 0; an all-zero stream predicts correctly and locks after 8+SYNC_LEN bits.
// STRUCTURE
//  - Package lfsr_pkg: LFSR_W=8, LFSR_TAPS=8'hB8 (bits 7,5,4,3), LFSR_SEED=8'h01,
//    typedef enum {CHK_SEARCH, CHK_LOCKED} chk_state_t.
//  - Sub-module lfsr_tap: combinational feedback bit from state and LFSR_TAPS; reusable by the generator.
//  - Counters and FSM stay in lfsr_checker.
// TESTING
//  1. Reset, clean stream from reference LFSR seeded 8'h01, bit_valid=1 -> locked rises cycle after bit 24;
//     after bit 200: err_count=0, bit_count=176.
//  2. Locked, invert one bit -> one err_pulse next cycle, err_count=1, locked stays 1, next bits match.
//  3. Locked, invert 4 bits inside one 64-bit window -> locked=0 cycle after 4th error, err_count=4;
//     resume clean stream -> relock after 24 further valid bits, err_count still 4.
//  4. bit_valid toggling 1/0 with clean stream -> lock on 24th valid bit; no change on invalid cycles.
//  5. 40 zero bits from reset: with LFSR_CHK_ZERO_DET_EN zero_stuck=1 cycle after 9th bit, locked=0;
//     without it locked=1 cycle after bit 24, zero_stuck=0.
//  6. clear with a simultaneous error -> err_count=0 next cycle; reset=0 while locked -> locked, counts,
//     err_pulse all 0 immediately.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared constants and types for the 8-bit LFSR stream (x^8+x^6+x^5+x^4+1).
package lfsr_pkg;
  localparam int              LFSR_W    = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'h01;

  typedef enum logic {CHK_SEARCH, CHK_LOCKED} chk_state_t;
endpackage

// File: rtl/lfsr_tap.sv
// Feedback bit of the LFSR: XOR of the tapped state bits. Shared with the generator.
module lfsr_tap
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] state_i,
  output logic              fb_o
);
  assign fb_o = ^(state_i & LFSR_TAPS);
endmodule

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: self-syncs a local reference, then counts bit errors while locked.
// Optional LFSR_CHK_ZERO_DET_EN: flag an all-zero line in SEARCH and refuse to lock on it.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int SYNC_LEN   = 16,
  parameter int WIN_LEN    = 64,
  parameter int ERR_THRESH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count,
  output logic             zero_stuck
);
  localparam int SW = $clog2(SYNC_LEN + 1);
  localparam int WW = $clog2(WIN_LEN + 1);
  localparam int EW = $clog2(ERR_THRESH + 1);
  localparam logic [SW-1:0]    SYNC_LAST = SW'(SYNC_LEN - 1);
  localparam logic [WW-1:0]    WIN_LAST  = WW'(WIN_LEN - 1);
  localparam logic [EW-1:0]    ERR_LAST  = EW'(ERR_THRESH - 1);
  localparam logic [3:0]       FILL_N    = 4'(LFSR_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  chk_state_t        state_q, state_d;
  logic [LFSR_W-1:0] shreg_q, shreg_d;
  logic [3:0]        fill_q, fill_d;
  logic [SW-1:0]     sync_q, sync_d;
  logic [WW-1:0]     win_q, win_d;
  logic [EW-1:0]     werr_q, werr_d;
  logic [CNT_W-1:0]  errc_q, errc_d, bitc_q, bitc_d;
  logic              pulse_q, pulse_d, zero_q, zero_d;
  logic              pred, mis, filled, zero_hit;

  lfsr_tap u_tap (.state_i(shreg_q), .fb_o(pred));

  assign mis    = bit_in != pred;
  assign filled = fill_q == FILL_N;

`ifdef LFSR_CHK_ZERO_DET_EN
  // Shifting in a 0 behind seven zeros lands on the LFSR lock-up state.
  assign zero_hit = filled && !bit_in && (shreg_q[LFSR_W-2:0] == '0);
`else
  assign zero_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CHK_SEARCH;
      shreg_q <= '0;
      fill_q  <= '0;
      sync_q  <= '0;
      win_q   <= '0;
      werr_q  <= '0;
      errc_q  <= '0;
      bitc_q  <= '0;
      pulse_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      fill_q  <= fill_d;
      sync_q  <= sync_d;
      win_q   <= win_d;
      werr_q  <= werr_d;
      errc_q  <= errc_d;
      bitc_q  <= bitc_d;
      pulse_q <= pulse_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    fill_d  = fill_q;
    sync_d  = sync_q;
    win_d   = win_q;
    werr_d  = werr_q;
    errc_d  = errc_q;
    bitc_d  = bitc_q;
    pulse_d = 1'b0;
    zero_d  = zero_q;
    if (bit_valid) begin
      case (state_q)
        CHK_SEARCH: begin
          shreg_d = {shreg_q[LFSR_W-2:0], bit_in};
          if (zero_hit)    zero_d = 1'b1;
          else if (bit_in) zero_d = 1'b0;
          if (!filled) begin
            fill_d = fill_q + 4'd1;
          end else if (zero_hit || mis) begin
            sync_d = '0;
          end else if (sync_q == SYNC_LAST) begin
            state_d = CHK_LOCKED;
            sync_d  = '0;
          end else begin
            sync_d = sync_q + 1'b1;
          end
        end
        default: begin
          // Reference free-runs on its own prediction; line errors never reach it.
          shreg_d = {shreg_q[LFSR_W-2:0], pred};
          pulse_d = mis;
          bitc_d  = (bitc_q == CNT_MAX) ? bitc_q : bitc_q + 1'b1;
          if (mis && errc_q != CNT_MAX) errc_d = errc_q + 1'b1;
          if (mis && werr_q == ERR_LAST) begin
            state_d = CHK_SEARCH;
            fill_d  = '0;
            sync_d  = '0;
            win_d   = '0;
            werr_d  = '0;
          end else if (win_q == WIN_LAST) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d  = win_q + 1'b1;
            werr_d = werr_q + EW'(mis);
          end
        end
      endcase
    end
    if (clear) begin
      errc_d = '0;
      bitc_d = '0;
    end
  end

  assign locked     = state_q == CHK_LOCKED;
  assign err_pulse  = pulse_q;
  assign err_count  = errc_q;
  assign bit_count  = bitc_q;
  assign zero_stuck = zero_q;
endmodule
